// File: rtl/uart_rx_core.sv
// UART receiver core: 16x oversampled line, majority-of-three bit decision, 5-8 data bits,
// optional parity, one or two stop bits; each completed frame is strobed out with RxDone.
module uart_rx_core #(
  parameter int OVS = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        RxEn,
  input  logic        RxD,
  input  logic [11:0] UBRR,
  input  logic [1:0]  DLS,
  input  logic        STOP,
  input  logic        PEN,
  input  logic        EPS,
  output logic [7:0]  RxData,
  output logic        RxDone,
  output logic        RxStopBit,
  output logic        RxParityErr,
  output logic        RxBusy
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

  localparam logic [3:0] PH_LAST = 4'(OVS - 1);
  localparam logic [3:0] PH_MID  = 4'(OVS / 2 + 1);
  localparam logic [3:0] PH_S1   = PH_MID - 4'd2;
  localparam logic [3:0] PH_S2   = PH_MID - 4'd1;

  state_t      state_q;
  logic        sync1_q, rxs_q, rxs_prev_q;
  logic [11:0] baud_q, baud_d;
  logic [3:0]  phase_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic        samp1_q, samp2_q, par_bit_q, stop1_q;
  logic [1:0]  dls_q;
  logic        stop_q, pen_q, eps_q;
  logic [7:0]  rx_data_q;
  logic        rx_done_q, rx_stop_q, rx_perr_q, rx_busy_q;

  logic       tick, mid, wrap, bit_val, last_stop, stop_val, par_x;
  logic [2:0] last_idx;

  always_comb begin
    tick      = RxEn && (baud_q >= UBRR);
    baud_d    = tick ? 12'd0 : baud_q + 12'd1;
    mid       = tick && (phase_q == PH_MID);
    wrap      = tick && (phase_q == PH_LAST);
    bit_val   = (samp1_q & samp2_q) | (samp1_q & rxs_q) | (samp2_q & rxs_q);
    last_idx  = 3'd4 + {1'b0, dls_q};
    last_stop = mid && (((state_q == STOP1) && !stop_q) || (state_q == STOP2));
    stop_val  = (state_q == STOP2) ? (stop1_q & bit_val) : bit_val;
    par_x     = (^shift_q) ^ par_bit_q;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
      state_q    <= IDLE;
      baud_q     <= '0;
      phase_q    <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      samp1_q    <= 1'b0;
      samp2_q    <= 1'b0;
      par_bit_q  <= 1'b0;
      stop1_q    <= 1'b0;
      dls_q      <= '0;
      stop_q     <= 1'b0;
      pen_q      <= 1'b0;
      eps_q      <= 1'b0;
      rx_data_q  <= '0;
      rx_done_q  <= 1'b0;
      rx_stop_q  <= 1'b1;
      rx_perr_q  <= 1'b0;
      rx_busy_q  <= 1'b0;
    end else begin
      sync1_q    <= RxD;
      rxs_q      <= sync1_q;
      rxs_prev_q <= rxs_q;
      rx_done_q  <= 1'b0;
      if (!RxEn) begin
        state_q   <= IDLE;
        rx_busy_q <= 1'b0;
        baud_q    <= '0;
        phase_q   <= '0;
      end else begin
        baud_q <= baud_d;
        if (state_q != IDLE && tick) begin
          phase_q <= phase_q + 4'd1;
          if (phase_q == PH_S1) samp1_q <= rxs_q;
          if (phase_q == PH_S2) samp2_q <= rxs_q;
        end
        case (state_q)
          IDLE: if (rxs_prev_q && !rxs_q) begin
            // Configuration is frozen here so mid-frame register writes cannot corrupt it.
            dls_q     <= DLS;
            stop_q    <= STOP;
            pen_q     <= PEN;
            eps_q     <= EPS;
            baud_q    <= '0;
            phase_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            par_bit_q <= 1'b0;
            stop1_q   <= 1'b0;
            state_q   <= START;
            rx_busy_q <= 1'b1;
          end
          START: begin
            if (mid && bit_val) begin
              state_q   <= IDLE;
              rx_busy_q <= 1'b0;
            end else if (wrap) begin
              state_q <= DATA;
            end
          end
          DATA: begin
            if (mid) shift_q[bit_idx_q] <= bit_val;
            if (wrap) begin
              if (bit_idx_q == last_idx) state_q <= pen_q ? PARITY : STOP1;
              else bit_idx_q <= bit_idx_q + 3'd1;
            end
          end
          PARITY: begin
            if (mid) par_bit_q <= bit_val;
            if (wrap) state_q <= STOP1;
          end
          STOP1: begin
            if (mid && stop_q) stop1_q <= bit_val;
            if (wrap) state_q <= STOP2;
          end
          STOP2: ;
          default: state_q <= IDLE;
        endcase
        // Finish mid-way through the last stop bit so a back-to-back start edge is not missed.
        if (last_stop) begin
          rx_data_q <= shift_q;
          rx_stop_q <= stop_val;
          rx_perr_q <= pen_q & (eps_q ? par_x : ~par_x);
          rx_done_q <= 1'b1;
          state_q   <= IDLE;
          rx_busy_q <= 1'b0;
        end
      end
    end
  end

  assign RxData      = rx_data_q;
  assign RxDone      = rx_done_q;
  assign RxStopBit   = rx_stop_q;
  assign RxParityErr = rx_perr_q;
  assign RxBusy      = rx_busy_q;
endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed frames plus randomized frames against a frame-level model.
module tb_uart_rx_core;
  logic        PCLK = 1'b0;
  logic        PRESETn, RxEn, RxD;
  logic [11:0] UBRR;
  logic [1:0]  DLS;
  logic        STOP, PEN, EPS;
  logic [7:0]  RxData;
  logic        RxDone, RxStopBit, RxParityErr, RxBusy;

  always #5 PCLK = ~PCLK;

  uart_rx_core #(.OVS(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .RxEn(RxEn), .RxD(RxD), .UBRR(UBRR),
    .DLS(DLS), .STOP(STOP), .PEN(PEN), .EPS(EPS), .RxData(RxData), .RxDone(RxDone),
    .RxStopBit(RxStopBit), .RxParityErr(RxParityErr), .RxBusy(RxBusy)
  );

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       perr;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur;
  int         n_checks = 0, n_errors = 0;
  int         cyc = 0, done_cnt = 0, last_done_cyc = 0, last_start_cyc = 0;
  logic [7:0] hold_data = 8'h00;
  logic       hold_stop = 1'b1, hold_perr = 1'b0;

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: every RxDone must match the oldest pending frame, outputs hold otherwise.
  always @(negedge PCLK) begin
    if (!PRESETn) begin
      hold_data = 8'h00;
      hold_stop = 1'b1;
      hold_perr = 1'b0;
    end else if (RxDone === 1'b1) begin
      done_cnt++;
      last_done_cyc = cyc;
      check("frame_pending_at_done", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        check("done_data", RxData, cur.data);
        check("done_stop", RxStopBit, cur.stop);
        check("done_perr", RxParityErr, cur.perr);
        check("done_cycle", cyc, cur.cyc);
        hold_data = cur.data;
        hold_stop = cur.stop;
        hold_perr = cur.perr;
      end
    end else begin
      check("outputs_held", {RxData, RxStopBit, RxParityErr}, {hold_data, hold_stop, hold_perr});
    end
  end

  task automatic idle(input int bits);
    RxD = 1'b1;
    repeat (bits * 16 * (int'(UBRR) + 1)) @(negedge PCLK);
  endtask

  // abort_mode: 0 = complete frame, 1 = drop RxEn in bit abort_bit, 2 = reset in bit abort_bit.
  task automatic send_frame(input logic [7:0] data, input int n, input bit pen, input bit eps,
                            input bit two, input bit pbit, input bit s1, input bit s2,
                            input int abort_bit, input int abort_mode, input bit scramble);
    int         t, nb;
    logic       b[12];
    exp_t       e;
    logic [7:0] dm;
    logic       x;
    t    = 16 * (int'(UBRR) + 1);
    DLS  = 2'(n - 5);
    STOP = two;
    PEN  = pen;
    EPS  = eps;
    dm   = data & 8'((1 << n) - 1);
    nb = 0;
    b[nb] = 1'b0; nb++;
    for (int i = 0; i < n; i++) begin b[nb] = dm[i]; nb++; end
    if (pen) begin b[nb] = pbit; nb++; end
    b[nb] = s1; nb++;
    if (two) begin b[nb] = s2; nb++; end
    x      = (^dm) ^ pbit;
    e.data = dm;
    e.stop = two ? (s1 & s2) : s1;
    e.perr = pen & (eps ? x : ~x);
    // Done appears 3 cycles of sync/edge latency after the start edge plus 10 ticks into the last bit.
    e.cyc  = cyc + 3 + (16 * (nb - 1) + 10) * (t / 16);
    last_start_cyc = cyc;
    if (abort_mode == 0) exp_q.push_back(e);
    for (int j = 0; j < nb; j++) begin
      RxD = b[j];
      repeat (t / 2) @(negedge PCLK);
      if (j == 1) check("busy_in_data", RxBusy, 1);
      if (scramble && j == 1) begin
        DLS  = 2'($urandom);
        STOP = 1'($urandom);
        PEN  = 1'($urandom);
        EPS  = 1'($urandom);
      end
      if (abort_mode != 0 && j == abort_bit) begin
        if (abort_mode == 1) begin
          RxEn = 1'b0;
          @(negedge PCLK);
          check("busy_after_disable", RxBusy, 0);
          RxD = 1'b1;
          repeat (t) @(negedge PCLK);
          RxEn = 1'b1;
        end else begin
          PRESETn = 1'b0;
          @(negedge PCLK);
          check("midreset_data", RxData, 8'h00);
          check("midreset_busy", RxBusy, 0);
          check("midreset_stop", RxStopBit, 1);
          PRESETn = 1'b1;
          RxD = 1'b1;
          repeat (t) @(negedge PCLK);
        end
        return;
      end
      repeat (t - t / 2) @(negedge PCLK);
    end
  endtask

  initial begin
    int d0, n;
    PRESETn = 1'b0; RxEn = 1'b1; RxD = 1'b1; UBRR = 12'd0;
    DLS = 2'd3; STOP = 1'b0; PEN = 1'b0; EPS = 1'b0;
    repeat (3) @(negedge PCLK);
    check("reset_data", RxData, 8'h00);
    check("reset_done", RxDone, 0);
    check("reset_stop", RxStopBit, 1);
    check("reset_perr", RxParityErr, 0);
    check("reset_busy", RxBusy, 0);
    PRESETn = 1'b1;
    repeat (4) @(negedge PCLK);

    // 8N1 0xA5 at 16 cycles per bit
    send_frame(8'hA5, 8, 0, 0, 0, 0, 1, 1, -1, 0, 0);
    check("a5_latency", last_done_cyc - last_start_cyc, 157);
    idle(1);
    check("a5_data", RxData, 8'hA5);
    check("a5_stop", RxStopBit, 1);
    check("a5_perr", RxParityErr, 0);
    check("a5_done_count", done_cnt, 1);

    // 7E1 0x35, good then bad parity bit
    send_frame(8'h35, 7, 1, 1, 0, 0, 1, 1, -1, 0, 0);
    idle(1);
    check("7e1_data", RxData, 8'h35);
    check("7e1_perr_ok", RxParityErr, 0);
    send_frame(8'h35, 7, 1, 1, 0, 1, 1, 1, -1, 0, 0);
    idle(1);
    check("7e1_perr_bad", RxParityErr, 1);

    // Framing error, line held low for 40 bit times, then recovery
    d0 = done_cnt;
    send_frame(8'h55, 8, 0, 0, 0, 0, 0, 1, -1, 0, 0);
    repeat (40 * 16) @(negedge PCLK);
    check("ferr_done_count", done_cnt - d0, 1);
    check("ferr_stop", RxStopBit, 0);
    check("ferr_data", RxData, 8'h55);
    idle(2);
    send_frame(8'h12, 8, 0, 0, 0, 0, 1, 1, -1, 0, 0);
    idle(1);
    check("recover_data", RxData, 8'h12);
    check("recover_stop", RxStopBit, 1);

    // False start: 4-cycle glitch
    d0 = done_cnt;
    RxD = 1'b0;
    repeat (4) @(negedge PCLK);
    check("glitch_busy_high", RxBusy, 1);
    RxD = 1'b1;
    repeat (9) @(negedge PCLK);
    check("glitch_busy_low", RxBusy, 0);
    idle(2);
    check("glitch_no_done", done_cnt - d0, 0);
    check("glitch_data", RxData, 8'h12);

    // Abort by RxEn during data bit 3, then a clean 0x3C
    UBRR = 12'd1;
    d0 = done_cnt;
    send_frame(8'h96, 8, 0, 0, 0, 0, 1, 1, 4, 1, 0);
    idle(1);
    check("abort_no_done", done_cnt - d0, 0);
    send_frame(8'h3C, 8, 0, 0, 0, 0, 1, 1, -1, 0, 0);
    idle(1);
    check("abort_recover_data", RxData, 8'h3C);

    // 5 bits, two stop bits, second stop low
    UBRR = 12'd2;
    send_frame(8'h1F, 5, 0, 0, 1, 0, 1, 0, -1, 0, 0);
    check("5b2s_latency", last_done_cyc - last_start_cyc, 369);
    idle(1);
    check("5b2s_data", RxData, 8'h1F);
    check("5b2s_stop", RxStopBit, 0);

    // Reset mid-frame
    UBRR = 12'd1;
    d0 = done_cnt;
    send_frame(8'h77, 8, 0, 0, 0, 0, 1, 1, 4, 2, 0);
    idle(2);
    check("midreset_no_done", done_cnt - d0, 0);
    send_frame(8'hC3, 8, 0, 0, 0, 0, 1, 1, -1, 0, 0);
    idle(1);
    check("midreset_recover_data", RxData, 8'hC3);

    // Randomized frames with configuration scrambled mid-frame
    for (int k = 0; k < 24; k++) begin
      UBRR = 12'($urandom_range(0, 2));
      n = $urandom_range(5, 8);
      send_frame(8'($urandom), n, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, -1, 0, 1);
      idle(1);
    end

    idle(2);
    check("pending_frames", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter OVS, default 16, meaning baud ticks per bit, with OVS=16 the only supported value.
REQ-002 SHALL have port PCLK  in  1  system clock; all logic rising-edge.
REQ-003 SHALL have port PRESETn  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port RxEn  in  1  receiver enable (ControlReg0[1]).
REQ-005 SHALL have port RxD  in  1  serial line, asynchronous, idle high.
REQ-006 SHALL have port UBRR  in  12  baud divisor {UBRRH, UBRR}.
REQ-007 SHALL have port DLS  in  2  data length, N = 5 + DLS bits.
REQ-008 SHALL have port STOP  in  1  0 = one stop bit, 1 = two stop bits.
REQ-009 SHALL have ports PEN  in  1  parity enable, and EPS  in  1  1 = even parity, 0 = odd parity.
REQ-010 SHALL have port RxData  out  8  received character, right-justified, unused upper bits 0.
REQ-011 SHALL have port RxDone  out  1  one-PCLK pulse when a frame completes.
REQ-012 SHALL have ports RxStopBit  out  1  (1 = all stop bits sampled high), RxParityErr  out  1, and RxBusy  out  1  (high when state != IDLE).

Function
REQ-013 SHALL pass RxD through a 2-flop synchronizer with both flops reset to 1; all logic uses the synchronized value rxs.
REQ-014 SHALL run a 12-bit baud counter only while RxEn=1; when count >= UBRR, assert a tick for one cycle and reload 0, otherwise increment; this gives a tick period of UBRR+1 cycles, covers UBRR=0 (tick every cycle), and prevents wrap on a mid-frame UBRR decrease.
REQ-015 SHALL define states IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-016 SHALL keep a 4-bit phase counter that is cleared on frame start, incremented on each tick, and wraps 15->0 at the bit boundary.
REQ-017 SHALL decide each bit value on the tick where phase=9, as the majority of rxs samples taken at phases 7, 8 and 9.
REQ-018 IDLE: when rxs_prev=1 and rxs=0 (falling edge, checked every PCLK) and RxEn=1, latch DLS/STOP/PEN/EPS, clear phase and the baud counter, and go to START; a low level without a preceding high does not start a frame.
REQ-019 START: if the bit decided at phase 9 is 1 (false start), return to IDLE with no RxDone; if it is 0, go to DATA at the phase 15->0 wrap.
REQ-020 DATA: shift bits in LSB first; after bit N-1 is decided, go to PARITY if PEN, otherwise to STOP1, at the wrap.
REQ-021 PARITY: set RxParityErr = (XOR of N data bits ^ parity bit) != 0 when EPS=1, and == 0 when EPS=0; RxParityErr SHALL be 0 when PEN=0.
REQ-022 STOP1/STOP2: at phase 9 of the last stop bit (STOP1 if the latched STOP=0, otherwise STOP2), set RxStopBit to the AND of the stop bits, load RxData, update RxParityErr, pulse RxDone, and go to IDLE in the same cycle without waiting for the wrap.
REQ-023 SHALL update RxData, RxStopBit and RxParityErr only with RxDone and hold them otherwise.
REQ-024 SHALL leave configuration changes mid-frame without effect until the next start edge.
REQ-025 SHALL, when RxEn=0 in any state, synchronously force IDLE and clear the phase and baud counters, with no RxDone and with data outputs held.
REQ-026 SHALL, after a framing error with RxD held low, start no frame until rxs returns high and then falls.

Reset
REQ-027 SHALL, on PRESETn=0, asynchronously set state=IDLE, counters=0, synchronizer=11, RxData=8'h00, RxDone=0, RxStopBit=1, RxParityErr=0, RxBusy=0.
REQ-028 SHALL, when reset is asserted mid-frame, discard the frame, produce no RxDone after release, and resume start detection after release.

Verification
REQ-029 SHALL cover 8N1 with UBRR=0, DLS=3, RxD=0xA5 at 16 cycles/bit -> one RxDone pulse, RxData=0xA5, RxStopBit=1, RxParityErr=0.
REQ-030 SHALL cover 7E1 with DLS=2, PEN=1, EPS=1, data 0x35 and parity bit 0 -> RxData=0x35, RxParityErr=0; the same frame with parity bit 1 -> RxParityErr=1.
REQ-031 SHALL cover a framing error: 8N1 0x55 with the stop bit low and the line held low for 40 bit times -> exactly one RxDone, RxStopBit=0; then a high-then-0x12 frame -> RxData=0x12.
REQ-032 SHALL cover a false start with UBRR=0 and a 4-cycle low glitch -> RxBusy pulses, returns to 0 by phase 9, no RxDone, RxData unchanged.
REQ-033 SHALL cover abort: RxEn dropped during data bit 3 -> RxBusy=0 next cycle and no RxDone; then re-enable and receive 0x3C -> RxData=0x3C.
REQ-034 SHALL cover 5-bit with two stop bits: UBRR=2, DLS=0, STOP=1, data 0x1F with the second stop bit low -> RxData=0x1F, RxStopBit=0, RxDone 48*(1+5+1)+3*16*... i.e. at phase 9 of STOP2.
